// File: rtl/vga_pkg.sv
// vga_pkg: shared colours, timing defaults and pipeline record types for the VGA stages
package vga_pkg;
    typedef logic [11:0] rgb_t;
    localparam int H_ACTIVE_DEF = 800;
    localparam int V_ACTIVE_DEF = 600;
    localparam rgb_t BLACK      = 12'h000;
    localparam rgb_t BORDER_TOP = 12'hff0;
    localparam rgb_t BORDER_BOT = 12'hf00;
    localparam rgb_t BORDER_L   = 12'h0f0;
    localparam rgb_t BORDER_R   = 12'h00f;
    localparam rgb_t GRASS      = 12'h080;
    localparam rgb_t WHITE      = 12'hfff;
    localparam rgb_t ROAD       = 12'h555;
    typedef enum logic [2:0] {BRD_NONE, BRD_TOP, BRD_BOT, BRD_L, BRD_R} border_t;
    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
    } timing_t;
    typedef struct packed {
        logic    blank;
        border_t border;
        logic    grass;
        logic    edge_ln;
        logic    ctr;
        logic    dash;
    } flags_t;
endpackage

// File: rtl/scroll_counter.sv
// scroll_counter: advances the dash scroll offset once per frame on the vblank rising edge
module scroll_counter #(
    parameter int DASH_PERIOD = 64
) (
    input  logic                           pclk,
    input  logic                           rst,
    input  logic                           vblnk_in,
    input  logic                           scroll_en,
    input  logic [3:0]                     speed,
    output logic [$clog2(DASH_PERIOD)-1:0] scroll_pos
);
    localparam int PW = $clog2(DASH_PERIOD);
    logic          vblnk_prev_q;
    logic [PW-1:0] scroll_pos_q, scroll_pos_d;
    always_comb scroll_pos_d = (vblnk_in & ~vblnk_prev_q & scroll_en) ? scroll_pos_q + PW'(speed) : scroll_pos_q;
    // prev starts high so a vblank already active at release is not an edge
    always_ff @(posedge pclk) begin
        if (rst) begin
            vblnk_prev_q <= 1'b1;
            scroll_pos_q <= '0;
        end else begin
            vblnk_prev_q <= vblnk_in;
            scroll_pos_q <= scroll_pos_d;
        end
    end
    assign scroll_pos = scroll_pos_q;
endmodule

// File: rtl/draw_background_scroll.sv
// draw_background_scroll: two-stage road/grass/dashed-centre background with per-frame scrolling
module draw_background_scroll
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int ROAD_L      = 200,
    parameter int ROAD_R      = 599,
    parameter int CENTER      = 400,
    parameter int LINE_W      = 8,
    parameter int DASH_PERIOD = 64,
    parameter int DASH_LEN    = 32
) (
    input  logic                           pclk,
    input  logic                           rst,
    input  logic [10:0]                    hcount_in,
    input  logic [10:0]                    vcount_in,
    input  logic                           hsync_in,
    input  logic                           vsync_in,
    input  logic                           hblnk_in,
    input  logic                           vblnk_in,
    input  logic                           scroll_en,
    input  logic [3:0]                     speed,
    output logic [10:0]                    hcount_out,
    output logic [10:0]                    vcount_out,
    output logic                           hsync_out,
    output logic                           vsync_out,
    output logic                           hblnk_out,
    output logic                           vblnk_out,
    output logic [11:0]                    rgb_out,
    output logic [$clog2(DASH_PERIOD)-1:0] scroll_pos
);
    localparam int PW = $clog2(DASH_PERIOD);
    localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
    localparam logic [10:0] V_LAST = 11'(V_ACTIVE - 1);
    localparam logic [10:0] RL     = 11'(ROAD_L);
    localparam logic [10:0] RR     = 11'(ROAD_R);
    localparam logic [10:0] EL_HI  = 11'(ROAD_L + LINE_W - 1);
    localparam logic [10:0] ER_LO  = 11'(ROAD_R - LINE_W + 1);
    localparam logic [10:0] C_LO   = 11'(CENTER - LINE_W / 2);
    localparam logic [10:0] C_HI   = 11'(CENTER + LINE_W / 2 - 1);
    localparam logic [PW-1:0] DL   = PW'(DASH_LEN);
    timing_t       t_in, t1_q, t2_q;
    flags_t        f_d, f1_q;
    rgb_t          rgb_d, rgb_q;
    logic [10:0]   dy_full;
    logic [PW-1:0] dash_y;
    scroll_counter #(.DASH_PERIOD(DASH_PERIOD)) u_scroll (
        .pclk      (pclk),
        .rst       (rst),
        .vblnk_in  (vblnk_in),
        .scroll_en (scroll_en),
        .speed     (speed),
        .scroll_pos(scroll_pos)
    );
    assign t_in    = '{h: hcount_in, v: vcount_in, hs: hsync_in, vs: vsync_in, hb: hblnk_in, vb: vblnk_in};
    assign dy_full = vcount_in - 11'(scroll_pos);
    assign dash_y  = dy_full[PW-1:0];
    always_comb begin
        f_d.blank   = hblnk_in | vblnk_in;
        f_d.border  = vcount_in == 11'd0 ? BRD_TOP :
                      vcount_in == V_LAST ? BRD_BOT :
                      hcount_in == 11'd0 ? BRD_L :
                      hcount_in == H_LAST ? BRD_R : BRD_NONE;
        f_d.grass   = hcount_in < RL || hcount_in > RR;
        f_d.edge_ln = (hcount_in >= RL && hcount_in <= EL_HI) || (hcount_in >= ER_LO && hcount_in <= RR);
        f_d.ctr     = hcount_in >= C_LO && hcount_in <= C_HI;
        f_d.dash    = dash_y < DL;
    end
    always_comb begin
        rgb_d = f1_q.blank ? BLACK :
                f1_q.border == BRD_TOP ? BORDER_TOP :
                f1_q.border == BRD_BOT ? BORDER_BOT :
                f1_q.border == BRD_L ? BORDER_L :
                f1_q.border == BRD_R ? BORDER_R :
                f1_q.grass ? GRASS :
                (f1_q.edge_ln || (f1_q.ctr && f1_q.dash)) ? WHITE : ROAD;
    end
    always_ff @(posedge pclk) begin
        if (rst) begin
            t1_q  <= '0;
            t2_q  <= '0;
            f1_q  <= '0;
            rgb_q <= '0;
        end else begin
            t1_q  <= t_in;
            f1_q  <= f_d;
            t2_q  <= t1_q;
            rgb_q <= rgb_d;
        end
    end
    assign hcount_out = t2_q.h;
    assign vcount_out = t2_q.v;
    assign hsync_out  = t2_q.hs;
    assign vsync_out  = t2_q.vs;
    assign hblnk_out  = t2_q.hb;
    assign vblnk_out  = t2_q.vb;
    assign rgb_out    = rgb_q;
endmodule

// File: tb/tb_draw_background_scroll.sv
// tb_draw_background_scroll: directed scoreboard bench for the scrolling road background
module tb_draw_background_scroll;
    typedef struct packed {
        logic [11:0] rgb;
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
    } exp_t;
    logic        pclk = 0, rst = 1;
    logic [10:0] hcount_in = 0, vcount_in = 0;
    logic        hsync_in = 0, vsync_in = 0, hblnk_in = 0, vblnk_in = 1;
    logic        scroll_en = 0;
    logic [3:0]  speed = 0;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;
    logic [5:0]  scroll_pos;
    exp_t        q[$];
    exp_t        act, exp_e;
    int          checks = 0, errors = 0;
    logic        issued = 0, v1 = 0, v2 = 0;

    draw_background_scroll dut (
        .pclk(pclk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .scroll_en(scroll_en), .speed(speed), .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out), .scroll_pos(scroll_pos)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) begin
        v1 <= issued;
        v2 <= v1;
    end

    always @(negedge pclk) begin
        if (v2) begin
            act = '{rgb: rgb_out, h: hcount_out, v: vcount_out, hs: hsync_out, vs: vsync_out, hb: hblnk_out, vb: vblnk_out};
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL pixel: output %h with no expected entry", act);
            end else begin
                exp_e = q.pop_front();
                if (act !== exp_e)
                begin
                    errors++;
                    $display("FAIL pixel (%0d,%0d): got rgb=%h h=%0d v=%0d sync=%b%b%b%b, want rgb=%h h=%0d v=%0d sync=%b%b%b%b",
                             exp_e.h, exp_e.v, act.rgb, act.h, act.v, act.hs, act.vs, act.hb, act.vb,
                             exp_e.rgb, exp_e.h, exp_e.v, exp_e.hs, exp_e.vs, exp_e.hb, exp_e.vb);
                end
            end
        end
    end

    task automatic pix(input int h, input int v, input logic hb, input logic vb,
                       input logic hs, input logic vs, input logic [11:0] rgb);
        @(negedge pclk);
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hblnk_in  = hb;
        vblnk_in  = vb;
        hsync_in  = hs;
        vsync_in  = vs;
        issued    = 1;
        q.push_back('{rgb: rgb, h: 11'(h), v: 11'(v), hs: hs, vs: vs, hb: hb, vb: vb});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge pclk);
            issued   = 0;
            vblnk_in = 0;
            hblnk_in = 0;
        end
    endtask

    task automatic frame(input logic [3:0] sp, input logic en);
        @(negedge pclk);
        issued    = 0;
        speed     = sp;
        scroll_en = en;
        vblnk_in  = 1;
        repeat (3) @(negedge pclk);
        vblnk_in  = 0;
        @(negedge pclk);
        scroll_en = 0;
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; vblnk_in = 1; scroll_en = 1; speed = 5; hcount_in = 123; vcount_in = 45; hsync_in = 1;
        repeat (3) @(negedge pclk);
        chk("reset_rgb", int'(rgb_out), 0);
        chk("reset_hcount", int'(hcount_out), 0);
        chk("reset_hsync", int'(hsync_out), 0);
        chk("reset_scroll", int'(scroll_pos), 0);
        rst = 0;
        repeat (10) @(negedge pclk);
        chk("release_vblnk_high_scroll", int'(scroll_pos), 0);
        scroll_en = 0;
        pix(300, 100, 0, 0, 0, 0, 12'h555);
        pix(400, 10,  0, 0, 1, 0, 12'hfff);
        pix(400, 40,  0, 0, 0, 1, 12'h555);
        pix(0,   0,   0, 0, 1, 1, 12'hff0);
        pix(150, 300, 0, 0, 0, 0, 12'h080);
        pix(200, 300, 0, 0, 0, 0, 12'hfff);
        pix(207, 300, 0, 0, 0, 0, 12'hfff);
        pix(208, 300, 0, 0, 0, 0, 12'h555);
        pix(599, 300, 0, 0, 0, 0, 12'hfff);
        pix(600, 300, 0, 0, 0, 0, 12'h080);
        pix(300, 599, 0, 0, 0, 0, 12'hf00);
        pix(0,   300, 0, 0, 0, 0, 12'h0f0);
        pix(799, 300, 0, 0, 0, 0, 12'h00f);
        pix(396, 31,  0, 0, 0, 0, 12'hfff);
        pix(404, 10,  0, 0, 0, 0, 12'h555);
        pix(400, 32,  0, 0, 0, 0, 12'h555);
        pix(400, 10,  1, 0, 1, 0, 12'h000);
        pix(0,   0,   0, 1, 0, 1, 12'h000);
        idle(3);
        chk("vblnk_pixel_no_scroll_when_disabled", int'(scroll_pos), 0);
        frame(8, 1);
        frame(8, 1);
        chk("scroll_16", int'(scroll_pos), 16);
        pix(400, 10, 0, 0, 0, 0, 12'h555);
        pix(400, 20, 0, 0, 0, 0, 12'hfff);
        idle(3);
        frame(15, 1);
        frame(15, 1);
        frame(14, 1);
        chk("scroll_60", int'(scroll_pos), 60);
        frame(7, 0);
        chk("scroll_hold_disabled", int'(scroll_pos), 60);
        frame(0, 1);
        chk("scroll_hold_speed0", int'(scroll_pos), 60);
        frame(7, 1);
        chk("scroll_wrap_3", int'(scroll_pos), 3);
        pix(400, 34, 0, 0, 0, 0, 12'hfff);
        pix(400, 35, 0, 0, 0, 0, 12'h555);
        pix(400, 2,  0, 0, 0, 0, 12'h555);
        pix(400, 3,  0, 0, 0, 0, 12'hfff);
        idle(5);
        chk("scoreboard_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
